// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD-search sequencer: state encoding,
// counter widths and the words-per-block decode.
package sad_pkg;

    localparam int SAD_BLK_W        = 5;
    localparam int SAD_WORD_W       = 4;
    localparam int SAD_W_ZERO_WORDS = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CMP   = 3'd3,
        ST_UPD   = 3'd4,
        ST_DONE  = 3'd5
    } sad_state_e;

    // Index of the last word in a block; a programmed count of 0 means 16 words.
    function automatic logic [SAD_WORD_W-1:0] sad_last_word(input logic [SAD_WORD_W-1:0] wpb);
        if (wpb == '0) begin
            return SAD_WORD_W'(SAD_W_ZERO_WORDS - 1);
        end
        return wpb - SAD_WORD_W'(1);
    endfunction

endpackage

// File: rtl/sad_sequencer.sv
// Control FSM for the SAD-search instruction: walks every candidate block,
// accumulates its SAD words, stores it and tracks the index of the minimum.
module sad_sequencer
    import sad_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SAD_BLK_W-1:0]  num_blocks,
    input  logic [SAD_WORD_W-1:0] words_per_block,
    input  logic                  flush,
    input  logic                  cmp_less,
    output logic                  stall,
    output logic                  readSAD,
    output logic                  acc_clr,
    output logic [SAD_WORD_W-1:0] word_addr,
    output logic [SAD_BLK_W-1:0]  block_idx,
    output logic                  SAD_RegFile_write,
    output logic                  small_big_find,
    output logic                  read_min,
    output logic                  write_min,
    output logic [SAD_BLK_W-1:0]  min_idx,
    output logic                  done
);

    sad_state_e            state_q, state_d;
    logic [SAD_WORD_W-1:0] word_addr_q, word_addr_d;
    logic [SAD_BLK_W-1:0]  block_idx_q, block_idx_d;
    logic [SAD_BLK_W-1:0]  min_idx_q, min_idx_d;
    logic [SAD_BLK_W-1:0]  nblk_q, nblk_d;
    logic [SAD_WORD_W-1:0] wlast_q, wlast_d;
    logic                  last_block;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_addr_q <= '0;
            block_idx_q <= '0;
            min_idx_q   <= '0;
            nblk_q      <= '0;
            wlast_q     <= '0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            block_idx_q <= block_idx_d;
            min_idx_q   <= min_idx_d;
            nblk_q      <= nblk_d;
            wlast_q     <= wlast_d;
        end
    end

    assign last_block = (block_idx_q == nblk_q - SAD_BLK_W'(1));

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        block_idx_d = block_idx_q;
        min_idx_d   = min_idx_q;
        nblk_d      = nblk_q;
        wlast_d     = wlast_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        nblk_d      = num_blocks;
                        wlast_d     = sad_last_word(words_per_block);
                        block_idx_d = '0;
                        word_addr_d = '0;
                        state_d     = (num_blocks != '0) ? ST_READ : ST_DONE;
                    end
                end
                ST_READ: begin
                    // Hold on the last word so the address never wraps.
                    if (word_addr_q == wlast_q) begin
                        state_d = ST_WRITE;
                    end else begin
                        word_addr_d = word_addr_q + SAD_WORD_W'(1);
                    end
                end
                ST_WRITE: state_d = ST_CMP;
                ST_CMP: begin
                    // Ties do not update, so the lowest index keeps the minimum.
                    if (block_idx_q == '0 || cmp_less) begin
                        state_d = ST_UPD;
                    end else if (last_block) begin
                        state_d = ST_DONE;
                    end else begin
                        block_idx_d = block_idx_q + SAD_BLK_W'(1);
                        word_addr_d = '0;
                        state_d     = ST_READ;
                    end
                end
                ST_UPD: begin
                    min_idx_d = block_idx_q;
                    if (last_block) begin
                        state_d = ST_DONE;
                    end else begin
                        block_idx_d = block_idx_q + SAD_BLK_W'(1);
                        word_addr_d = '0;
                        state_d     = ST_READ;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        // Reset is folded in so stall cannot follow start while rst is held.
        stall             = !rst && ((state_q == ST_IDLE && start) ||
                                     state_q == ST_READ || state_q == ST_WRITE ||
                                     state_q == ST_CMP  || state_q == ST_UPD);
        readSAD           = (state_q == ST_READ);
        acc_clr           = (state_q == ST_READ) && (word_addr_q == '0);
        SAD_RegFile_write = (state_q == ST_WRITE);
        small_big_find    = (state_q == ST_CMP) || (state_q == ST_UPD);
        read_min          = (state_q == ST_CMP);
        write_min         = (state_q == ST_UPD);
        done              = (state_q == ST_DONE);
    end

    assign word_addr = word_addr_q;
    assign block_idx = block_idx_q;
    assign min_idx   = min_idx_q;

endmodule
